// File: rtl/daq_frame_rx_checker_if.sv
// Frame word bus between the MAC FIFO (master) and the frame sink (slave).
// TXD/TXD_VLD flow toward the sink; TXACK returns the first-word acknowledge.
interface daq_frame_rx_checker_if;
  logic [15:0] TXD;
  logic        TXD_VLD;
  logic        TXACK;

  modport master (
    output TXD,
    output TXD_VLD,
    input  TXACK
  );

  modport slave (
    input  TXD,
    input  TXD_VLD,
    output TXACK
  );
endinterface

// File: rtl/daq_frame_rx_checker.sv
// Frame sink and checker: acknowledges each frame, checks an incrementing
// word pattern and the frame length, and keeps frame/error statistics.
module daq_frame_rx_checker #(
  parameter logic [3:0]  ACK_DLY   = 4'd4,
  parameter logic [15:0] DATA_MASK = 16'h0FFF,
  parameter logic [11:0] MAX_WORDS = 12'd4095
) (
  input  logic                    DAQ_DATA_CLK,
  input  logic                    RST_N,
  daq_frame_rx_checker_if.slave   frm,
  input  logic [11:0]             EXP_WORDS,
  input  logic                    CLR_STAT,
  output logic                    FRAME_DONE,
  output logic [11:0]             LAST_LEN,
  output logic [15:0]             FRAME_CNT,
  output logic [15:0]             ERR_CNT,
  output logic                    DATA_ERR,
  output logic                    LEN_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    ACK_WAIT,
    RECV,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  dly;
  logic [3:0]  dly_nx;
  logic        ack;
  logic        ack_nx;
  logic [11:0] wcnt;
  logic [11:0] wcnt_nx;
  logic [11:0] wcnt_inc;
  logic [15:0] prev;
  logic [15:0] prev_nx;
  logic        wait_low;
  logic        wait_low_nx;
  logic        f_data;
  logic        f_data_nx;
  logic        f_len;
  logic        f_len_nx;
  logic        mism;
  logic        mism_hit;
  logic        abort;
  logic        fin;
  logic        len_bad;
  logic        frame_bad;
  logic        err_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign wcnt_inc = wcnt + 12'd1;
  assign mism = ((frm.TXD ^ (prev + 16'd1)) & DATA_MASK) != 16'd0;

  always_comb begin
    state_nx    = state;
    dly_nx      = dly;
    ack_nx      = 1'b0;
    wcnt_nx     = wcnt;
    prev_nx     = prev;
    wait_low_nx = wait_low;
    f_data_nx   = f_data;
    f_len_nx    = f_len;
    mism_hit    = 1'b0;
    abort       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!frm.TXD_VLD) begin
          wait_low_nx = 1'b0;
        end else if (!wait_low) begin
          state_nx = ACK_WAIT;
          dly_nx   = ACK_DLY - 4'd1;
          ack_nx   = (ACK_DLY == 4'd1);
        end
      end
      ACK_WAIT: begin
        if (!frm.TXD_VLD) begin
          abort       = 1'b1;
          state_nx    = IDLE;
          wait_low_nx = 1'b1;
        end else if (ack) begin
          // word 0 seeds the pattern reference and is not checked
          state_nx  = (MAX_WORDS == 12'd1) ? DONE : RECV;
          prev_nx   = frm.TXD;
          wcnt_nx   = 12'd1;
          f_data_nx = 1'b0;
          f_len_nx  = (MAX_WORDS == 12'd1);
        end else begin
          dly_nx = dly - 4'd1;
          ack_nx = (dly == 4'd1);
        end
      end
      RECV: begin
        if (!frm.TXD_VLD) begin
          state_nx = DONE;
        end else begin
          wcnt_nx = wcnt_inc;
          prev_nx = frm.TXD;
          if (mism) begin
            f_data_nx = 1'b1;
            mism_hit  = 1'b1;
          end
          if (wcnt_inc == MAX_WORDS) begin
            f_len_nx = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx    = IDLE;
        wait_low_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge DAQ_DATA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      dly      <= 4'd0;
      ack      <= 1'b0;
      wcnt     <= 12'd0;
      prev     <= 16'd0;
      wait_low <= 1'b0;
      f_data   <= 1'b0;
      f_len    <= 1'b0;
    end else begin
      state    <= state_nx;
      dly      <= dly_nx;
      ack      <= ack_nx;
      wcnt     <= wcnt_nx;
      prev     <= prev_nx;
      wait_low <= wait_low_nx;
      f_data   <= f_data_nx;
      f_len    <= f_len_nx;
    end
  end

  assign fin = (state == DONE);
  assign len_bad = f_len |
    ((EXP_WORDS != 12'd0) && (wcnt != EXP_WORDS));
  assign frame_bad = f_data | len_bad;
  assign err_inc = abort | (fin & frame_bad);

  assign frm.TXACK  = ack;
  assign FRAME_DONE = fin;

  // a clear in the same clock as the end-of-frame update takes priority
  always_ff @(posedge DAQ_DATA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      LAST_LEN  <= 12'd0;
      FRAME_CNT <= 16'd0;
      ERR_CNT   <= 16'd0;
      DATA_ERR  <= 1'b0;
      LEN_ERR   <= 1'b0;
    end else if (CLR_STAT) begin
      LAST_LEN  <= 12'd0;
      FRAME_CNT <= 16'd0;
      ERR_CNT   <= 16'd0;
      DATA_ERR  <= 1'b0;
      LEN_ERR   <= 1'b0;
    end else begin
      if (mism_hit) DATA_ERR <= 1'b1;
      if (err_inc) ERR_CNT <= sat_inc(ERR_CNT);
      if (abort) LEN_ERR <= 1'b1;
      if (fin) begin
        LAST_LEN  <= wcnt;
        FRAME_CNT <= sat_inc(FRAME_CNT);
        if (len_bad) LEN_ERR <= 1'b1;
      end
    end
  end

endmodule
